mem_stage_lsu: RTL

Next-generation memory pipeline stage for the processor datapath. It registers the execute-stage result, then drives the data bus through a valid/ack handshake instead of a fire-and-forget write. Misaligned stores are split into two bus beats. Framebuffer pixel writes are queued in a parametrised FIFO so a slow video port back-pressures the pipeline instead of dropping pixels.

---
 rtl/mem_stage_lsu_if.sv | 38 +++
 rtl/mem_stage_lsu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Access-size encoding plus the data-bus and framebuffer-write handshake bundle.
// The LSU is master on both channels: it drives beats/queue head and samples ack/ready.
package mem_stage_lsu_pkg;
  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_t;
endpackage

interface mem_stage_lsu_if #(
  parameter int XW = 9,
  parameter int YW = 9,
  parameter int PW = 8
);
  logic          dbus_req;
  logic          dbus_ack;
  logic [31:0]   dbus_addr;
  logic [31:0]   dbus_wr_data;
  logic [3:0]    dbus_wr_en;
  logic          fb_wr_en;
  logic          fb_wr_ready;
  logic [XW-1:0] fb_wr_pxl_x;
  logic [YW-1:0] fb_wr_pxl_y;
  logic [PW-1:0] fb_wr_pxl_value;

  modport master (
    output dbus_req, dbus_addr, dbus_wr_data, dbus_wr_en,
    output fb_wr_en, fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value,
    input  dbus_ack, fb_wr_ready
  );

  modport slave (
    input  dbus_req, dbus_addr, dbus_wr_data, dbus_wr_en,
    input  fb_wr_en, fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value,
    output dbus_ack, fb_wr_ready
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: registers execute output, issues stores as valid/ack bus beats (misaligned split in two with MEM_MISALIGNED_SPLIT_EN, else flagged and dropped), queues pixel writes.
// Latency: non-memory 1 cycle; store 1 cycle + ack wait (+1 beat when split); pixel write 1 cycle.
// Backpressure: m_stall holds execute while a beat awaits ack or the pixel queue is full.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter  int MAIN_MEMORY_BYTES = 2048,
  parameter  int RESOLUTION_X      = 400,
  parameter  int RESOLUTION_Y      = 300,
  parameter  int PALETTE_LENGTH    = 256,
  parameter  int FB_FIFO_DEPTH     = 4,
  localparam int PCW = $clog2(MAIN_MEMORY_BYTES),
  localparam int XW  = $clog2(RESOLUTION_X),
  localparam int YW  = $clog2(RESOLUTION_Y),
  localparam int PW  = $clog2(PALETTE_LENGTH),
  localparam int AW  = $clog2(FB_FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            e_valid,
  input  logic [31:0]     e_alu_result,
  input  logic [31:0]     e_write_data,
  input  logic [4:0]      e_rd,
  input  logic [PCW-1:0]  e_pc_plus_4,
  input  mem_size_t       e_mem_size,
  input  logic            e_mem_write,
  input  logic            e_fb_write,
  output logic            m_stall,
  mem_stage_lsu_if.master bus,
  output logic            m_valid,
  output logic [31:0]     m_alu_result,
  output logic [4:0]      m_rd,
  output logic [PCW-1:0]  m_pc_plus_4,
  output logic            m_misaligned
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  localparam logic [AW:0] CNT_FULL = (AW+1)'(FB_FIFO_DEPTH);

  state_t      state, state_nxt;
  logic        m_vld, m_mem_write, m_fb_write;
  logic [31:0] m_write_data;
  mem_size_t   m_size;
  logic        retire, is_st, is_fb, split, two_beat, drop;
  logic [1:0]  a;
  logic [3:0]  size_mask, en0, en1;
  logic [4:0]  sh0;
  logic [5:0]  sh1;

  logic [XW+YW+PW-1:0] fifo_mem [FB_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic                full, empty, push, pop;
  logic [XW-1:0]       head_x;
  logic [YW-1:0]       head_y;
  logic [PW-1:0]       head_v;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_vld        <= 1'b0;
      m_alu_result <= '0;
      m_write_data <= '0;
      m_rd         <= '0;
      m_pc_plus_4  <= '0;
      m_size       <= MEM_SIZE_BYTE;
      m_mem_write  <= 1'b0;
      m_fb_write   <= 1'b0;
    end else if (!m_stall) begin
      m_vld        <= e_valid;
      m_alu_result <= e_alu_result;
      m_write_data <= e_write_data;
      m_rd         <= e_rd;
      m_pc_plus_4  <= e_pc_plus_4;
      m_size       <= e_mem_size;
      m_mem_write  <= e_mem_write;
      m_fb_write   <= e_fb_write;
    end
  end

  // A pixel write shadows a simultaneous store request.
  assign is_fb = m_vld && m_fb_write;
  assign is_st = m_vld && m_mem_write && !m_fb_write;
  assign a     = m_alu_result[1:0];
  assign split = (m_size == MEM_SIZE_WORD && a != 2'd0) ||
                 (m_size == MEM_SIZE_HALF && a == 2'd3);

`ifdef MEM_MISALIGNED_SPLIT_EN
  assign two_beat = split;
  assign drop     = 1'b0;
`else
  assign two_beat = 1'b0;
  assign drop     = split;
`endif

  always_comb begin
    size_mask = 4'b0001;
    case (m_size)
      MEM_SIZE_WORD: size_mask = 4'b1111;
      MEM_SIZE_HALF: size_mask = 4'b0011;
      default:       size_mask = 4'b0001;
    endcase
  end

  assign sh0 = {a, 3'b000};
  assign sh1 = 6'd32 - {1'b0, sh0};
  assign en0 = size_mask << a;
  assign en1 = size_mask >> (3'd4 - {1'b0, a});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    retire       = 1'b0;
    m_misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (is_st && !drop) begin
          state_nxt = BEAT0;
        end else if (m_vld) begin
          m_misaligned = is_st && drop;
          retire       = !(is_fb && full);
        end
      end
      BEAT0: begin
        if (bus.dbus_ack) begin
          if (two_beat) begin
            state_nxt = BEAT1;
          end else begin
            state_nxt = IDLE;
            retire    = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (bus.dbus_ack) begin
          state_nxt = IDLE;
          retire    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_valid = retire;
  assign m_stall = m_vld && !retire;

  always_comb begin
    bus.dbus_req     = 1'b0;
    bus.dbus_addr    = '0;
    bus.dbus_wr_data = '0;
    bus.dbus_wr_en   = '0;
    if (state == BEAT0) begin
      bus.dbus_req     = 1'b1;
      bus.dbus_addr    = {m_alu_result[31:2], 2'b00};
      bus.dbus_wr_data = m_write_data << sh0;
      bus.dbus_wr_en   = en0;
    end else if (state == BEAT1) begin
      bus.dbus_req     = 1'b1;
      bus.dbus_addr    = {m_alu_result[31:2], 2'b00} + 32'd4;
      bus.dbus_wr_data = m_write_data >> sh1;
      bus.dbus_wr_en   = en1;
    end
  end

  // Fullness is judged on the registered count, so a same-cycle pop cannot admit a push.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = is_fb && (state == IDLE) && !full;
  assign pop   = !empty && bus.fb_wr_ready;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {m_alu_result[XW-1:0], m_alu_result[16 +: YW], m_write_data[PW-1:0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign {head_x, head_y, head_v} = fifo_mem[rd_ptr];
  assign bus.fb_wr_en        = !empty;
  assign bus.fb_wr_pxl_x     = empty ? '0 : head_x;
  assign bus.fb_wr_pxl_y     = empty ? '0 : head_y;
  assign bus.fb_wr_pxl_value = empty ? '0 : head_v;

endmodule
